// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with start/busy/done handshake
//
// Purpose:
//   Load, clear, logical/arithmetic shift and rotate of a WIDTH-bit register
//   by a programmable amount. By default, multi-bit shifts step one bit per
//   clock. Define SHIFTREG_BARREL_EN to make every shift complete in a single
//   cycle using a combinational barrel shift.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous reset, active-high
//   start  in  1      command strobe, sampled only while idle
//   op     in  3      opcode, latched with start
//   amt    in  AMT_W  shift amount, latched with start
//   d_in   in  WIDTH  parallel load data (LOAD)
//   ser_in in  1      fill bit for SHL/SHR, sampled on every step
//   y      out WIDTH  register contents
//   busy   out 1      multi-cycle shift in progress
//   done   out 1      one-cycle pulse when a command has completed
//
// Opcodes:
//   000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_y;
    logic [AMT_W-1:0]   r_rem;
    logic [2:0]         r_op;
    logic               r_done;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_y_nxt;
    logic [AMT_W-1:0]   w_rem_nxt;
    logic [2:0]         w_op_nxt;
    logic               w_done_nxt;

    // One-bit step of any shift/rotate opcode; non-shift opcodes pass through.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_y,
        input logic             f_ser
    );
        logic [WIDTH-1:0] v;
        v = f_y;
        case (f_op)
            OP_SHL:  v = {f_y[WIDTH-2:0], f_ser};
            OP_SHR:  v = {f_ser, f_y[WIDTH-1:1]};
            OP_ROL:  v = {f_y[WIDTH-2:0], f_y[WIDTH-1]};
            OP_ROR:  v = {f_y[0], f_y[WIDTH-1:1]};
            OP_ASR:  v = {f_y[WIDTH-1], f_y[WIDTH-1:1]};
            default: v = f_y;
        endcase
        return v;
    endfunction

`ifdef SHIFTREG_BARREL_EN
    // Unrolled chain of single steps gated by the amount. Chaining single
    // steps gives exactly the serial result, including amt >= WIDTH
    // (logical shifts saturate to the fill bit, rotates wrap mod WIDTH).
    function automatic logic [WIDTH-1:0] f_barrel(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] f_y,
        input logic [AMT_W-1:0] f_amt,
        input logic             f_ser
    );
        logic [WIDTH-1:0] v;
        v = f_y;
        for (int i = 0; i < (2 ** AMT_W) - 1; i++) begin
            if (i < int'(f_amt)) begin
                v = f_step(f_op, v, f_ser);
            end
        end
        return v;
    endfunction
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_NOP: begin
                            w_done_nxt = 1'b1;
                        end
                        OP_LOAD: begin
                            w_y_nxt    = d_in;
                            w_done_nxt = 1'b1;
                        end
                        OP_CLR: begin
                            w_y_nxt    = '0;
                            w_done_nxt = 1'b1;
                        end
                        default: begin
`ifdef SHIFTREG_BARREL_EN
                            w_y_nxt    = f_barrel(op, r_y, amt, ser_in);
                            w_done_nxt = 1'b1;
`else
                            if (amt == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                // The first step happens on the accepting edge,
                                // so only amt-1 further steps remain.
                                w_y_nxt = f_step(op, r_y, ser_in);
                                if (amt == AMT_W'(1)) begin
                                    w_done_nxt = 1'b1;
                                end else begin
                                    w_state_nxt = ST_SHIFT;
                                    w_rem_nxt   = amt - 1'b1;
                                    w_op_nxt    = op;
                                end
                            end
`endif
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                w_y_nxt   = f_step(r_op, r_y, ser_in);
                w_rem_nxt = r_rem - 1'b1;
                if (r_rem == AMT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_rem   <= '0;
            r_op    <= OP_NOP;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign y    = r_y;
    assign busy = (r_state == ST_SHIFT);
    assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard testbench for univ_shift_reg
module tb_univ_shift_reg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [2:0] amt;
    logic [3:0] d_in;
    logic       ser_in;
    logic [3:0] y;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4), .AMT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .amt    (amt),
        .d_in   (d_in),
        .ser_in (ser_in),
        .y      (y),
        .busy   (busy),
        .done   (done)
    );

    // Snapshot comparisons: act/exp are {y, busy, done} or a counter value.
    typedef struct {
        string      tag;
        logic [5:0] act;
        logic [5:0] exp;
    } probe_t;

    probe_t     probe_q[$];
    logic [3:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Monitor: owns all counters. Pops expected results on every done pulse
    // and evaluates snapshot probes queued by the stimulus.
    initial begin : monitor
        probe_t     p;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                n_tests++;
                if (p.act !== p.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", p.tag, p.act, p.exp);
                end
            end
            if (done === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_done: got done=1 y=%b expected no done", y);
                end else begin
                    e = exp_q.pop_front();
                    if (y !== e || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL done_result: got y=%b busy=%b expected y=%b busy=0",
                                 y, busy, e);
                    end
                end
            end
        end
    end

    task automatic push_probe(input string tag, input logic [5:0] act, input logic [5:0] exp);
        probe_t p;
        p.tag = tag;
        p.act = act;
        p.exp = exp;
        probe_q.push_back(p);
    endtask

    // Called at a negedge: presents the command across the next rising edge.
    task automatic issue(input logic [2:0] i_op, input logic [2:0] i_amt,
                         input logic [3:0] i_din, input logic i_ser,
                         input logic [3:0] i_exp, input bit i_push);
        start  = 1'b1;
        op     = i_op;
        amt    = i_amt;
        d_in   = i_din;
        ser_in = i_ser;
        if (i_push) exp_q.push_back(i_exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) push_probe({"timeout_", tag}, 6'd1, 6'd0);
    endtask

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; op = OP_NOP; amt = 3'd0; d_in = 4'd0; ser_in = 1'b0;
        repeat (2) @(negedge clk);
        push_probe("reset_state", {y, busy, done}, {4'b0000, 1'b0, 1'b0});
        rst = 1'b0;

        // LOAD: result on the accepting edge, done for exactly one cycle
        @(negedge clk);
        issue(OP_LOAD, 3'd0, 4'b1011, 1'b0, 4'b1011, 1'b1);
        push_probe("load_edge", {y, busy, done}, {4'b1011, 1'b0, 1'b1});
        wait_done("load");
        @(negedge clk);
        push_probe("load_done_drop", {y, busy, done}, {4'b1011, 1'b0, 1'b0});

        // SHL by 2: serial shows the intermediate step with busy high
        issue(OP_SHL, 3'd2, 4'b0000, 1'b0, 4'b1100, 1'b1);
`ifdef SHIFTREG_BARREL_EN
        push_probe("shl2_first_edge", {y, busy, done}, {4'b1100, 1'b0, 1'b1});
`else
        push_probe("shl2_first_edge", {y, busy, done}, {4'b0110, 1'b1, 1'b0});
`endif
        wait_done("shl2");

        // Rotate by more than WIDTH, ASR saturation, SHR beyond WIDTH
        @(negedge clk); issue(OP_ROR,  3'd5, 4'b0000, 1'b0, 4'b0110, 1'b1); wait_done("ror5");
        @(negedge clk); issue(OP_LOAD, 3'd0, 4'b1000, 1'b0, 4'b1000, 1'b1); wait_done("load1000");
        @(negedge clk); issue(OP_ASR,  3'd3, 4'b0000, 1'b0, 4'b1111, 1'b1); wait_done("asr3");
        @(negedge clk); issue(OP_SHR,  3'd6, 4'b0000, 1'b0, 4'b0000, 1'b1); wait_done("shr6");

        // SHL by 3 with fill 1; a ROL strobe while busy must be ignored
        @(negedge clk); issue(OP_LOAD, 3'd0, 4'b0001, 1'b0, 4'b0001, 1'b1); wait_done("load0001");
        @(negedge clk); issue(OP_SHL,  3'd3, 4'b0000, 1'b1, 4'b1111, 1'b1);
`ifndef SHIFTREG_BARREL_EN
        push_probe("busy_during_shl3", {3'b000, busy, 2'b00}, {3'b000, 1'b1, 2'b00});
        issue(OP_ROL, 3'd1, 4'b0000, 1'b1, 4'b0000, 1'b0);
`endif
        wait_done("shl3");

        // Back-to-back: next command accepted in the done cycle
        @(negedge clk); issue(OP_LOAD, 3'd0, 4'b1010, 1'b0, 4'b1010, 1'b1); wait_done("load1010");
        @(negedge clk); issue(OP_ROL,  3'd3, 4'b0000, 1'b0, 4'b0101, 1'b1); wait_done("rol3");
        issue(OP_SHR, 3'd1, 4'b0000, 1'b1, 4'b1010, 1'b1);
        push_probe("b2b_shr1_edge", {y, busy, done}, {4'b1010, 1'b0, 1'b1});
        wait_done("shr1");

        // Shift by zero leaves y unchanged but still pulses done
        @(negedge clk); issue(OP_SHL, 3'd0, 4'b0000, 1'b1, 4'b1010, 1'b1); wait_done("shl0");

        // Reset in the middle of SHL by 7: no done pulse, y cleared
        @(negedge clk); issue(OP_LOAD, 3'd0, 4'b1001, 1'b0, 4'b1001, 1'b1); wait_done("load1001");
        @(negedge clk);
`ifdef SHIFTREG_BARREL_EN
        issue(OP_SHL, 3'd7, 4'b0000, 1'b0, 4'b0000, 1'b1);
`else
        issue(OP_SHL, 3'd7, 4'b0000, 1'b0, 4'b0000, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_probe("reset_abort", {y, busy, done}, {4'b0000, 1'b0, 1'b0});
        repeat (10) @(negedge clk);

        // NOP with nonzero amt: y unchanged, done pulse
        issue(OP_LOAD, 3'd0, 4'b1001, 1'b0, 4'b1001, 1'b1); wait_done("load1001b");
        @(negedge clk); issue(OP_NOP, 3'd5, 4'b0110, 1'b0, 4'b1001, 1'b1); wait_done("nop");

        repeat (4) @(negedge clk);
        push_probe("scoreboard_drain", 6'(exp_q.size()), 6'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
